// File: rtl/conv_ctrl.sv
// conv_ctrl: weight-load and frame-stream sequencer for the 5x5 convolution datapath.
// Tags each accepted pixel with window validity and delays the tag to line up with oPsum.
module conv_ctrl #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int DP_LAT = 133
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iStart,
  input  logic       iSkipW,
  input  logic       iAbort,
  input  logic       iWgtValid,
  input  logic [7:0] iWgt,
  output logic       oWgtReady,
  input  logic       iPixValid,
  input  logic [7:0] iPix,
  output logic       oPixReady,
  output logic       oWren,
  output logic [7:0] oWeight,
  output logic [4:0] oADDR,
  output logic [7:0] oX,
  output logic       oValid,
  output logic       oBusy,
  output logic       oDone,
  output logic       oErr
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOADW  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN    = CW'(4);
  localparam logic [RW-1:0] ROW_WIN    = RW'(4);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(DP_LAT - 1);
  localparam logic [4:0]    WGT_LAST   = 5'd24;

  logic [2:0]    r_state;
  logic [4:0]    r_wcnt;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [FW-1:0] r_fcnt;
  logic          r_wgt_loaded;
  logic [DP_LAT:0] r_pipe;
  logic          r_wren;
  logic [7:0]    r_weight;
  logic [4:0]    r_addr;
  logic [7:0]    r_x;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic [2:0] w_next;
  logic       w_start_ok;
  logic       w_wgt_acc;
  logic       w_pix_acc;
  logic       w_underrun;
  logic       w_last_pix;
  logic       w_tag;

  assign w_start_ok = (r_state == S_IDLE) && iStart && !iAbort;
  assign w_wgt_acc  = (r_state == S_LOADW) && iWgtValid && !iAbort;
  assign w_pix_acc  = (r_state == S_STREAM) && iPixValid && !iAbort;
  assign w_underrun = (r_state == S_STREAM) && !iPixValid && !iAbort;
  assign w_last_pix = w_pix_acc && (r_col == COL_LAST) && (r_row == ROW_LAST);
  assign w_tag      = w_pix_acc && (r_row >= ROW_WIN) && (r_col >= COL_WIN);

  // Next-state decode; abort overrides every transition.
  always_comb begin
    w_next = r_state;
    if (iAbort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (iStart && iSkipW && r_wgt_loaded) w_next = S_STREAM;
          else if (iStart)                      w_next = S_LOADW;
          else                                  w_next = S_IDLE;
        end
        S_LOADW: begin
          if (w_wgt_acc && (r_wcnt == WGT_LAST)) w_next = S_STREAM;
          else                                   w_next = S_LOADW;
        end
        S_STREAM: begin
          if (!iPixValid)      w_next = S_IDLE;
          else if (w_last_pix) w_next = S_FLUSH;
          else                 w_next = S_STREAM;
        end
        S_FLUSH: begin
          if (r_fcnt == FLUSH_LAST) w_next = S_FLUSH + 3'd1;
          else                      w_next = S_FLUSH;
        end
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // State and registered datapath-facing outputs.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wren   <= 1'b0;
      r_addr   <= 5'd0;
      r_weight <= 8'd0;
      r_x      <= 8'd0;
      r_pipe   <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
      r_wren  <= w_wgt_acc;
      if (w_wgt_acc) begin
        r_addr   <= r_wcnt;
        r_weight <= iWgt;
      end
      r_x <= w_pix_acc ? iPix : 8'd0;
      // A broken frame must never emit a late oValid, so the tag pipe is wiped.
      if (iAbort || w_underrun) r_pipe <= '0;
      else                      r_pipe <= {r_pipe[DP_LAT-1:0], w_tag};
    end
  end

  // Weight, pixel and flush counters plus the sticky status bits.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_wcnt       <= 5'd0;
      r_col        <= '0;
      r_row        <= '0;
      r_fcnt       <= '0;
      r_wgt_loaded <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (iAbort || w_start_ok) r_wcnt <= 5'd0;
      else if (w_wgt_acc)       r_wcnt <= r_wcnt + 5'd1;

      if (w_pix_acc && !w_last_pix) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end else begin
        r_col <= '0;
        r_row <= '0;
      end

      if ((r_state == S_FLUSH) && !iAbort) r_fcnt <= r_fcnt + FW'(1);
      else                                 r_fcnt <= '0;

      // Partially overwritten weights cannot be reused.
      if (iAbort && (r_state == S_LOADW))
        r_wgt_loaded <= 1'b0;
      else if (w_start_ok && (w_next == S_LOADW))
        r_wgt_loaded <= 1'b0;
      else if (w_wgt_acc && (r_wcnt == WGT_LAST))
        r_wgt_loaded <= 1'b1;

      if (w_underrun)      r_err <= 1'b1;
      else if (w_start_ok) r_err <= 1'b0;
    end
  end

  assign oWgtReady = (r_state == S_LOADW);
  assign oPixReady = (r_state == S_STREAM);
  assign oWren     = r_wren;
  assign oWeight   = r_weight;
  assign oADDR     = r_addr;
  assign oX        = r_x;
  assign oValid    = r_pipe[DP_LAT];
  assign oBusy     = r_busy;
  assign oDone     = r_done;
  assign oErr      = r_err;

endmodule
